// File: rtl/axis_dvp.sv
// axis_dvp: AXI-Stream video to DVP transmitter.
//
// Takes one pixel per clock from an AXIS stream (tuser = start of frame,
// tlast = end of line). Produces DVP framing from it: a vsync pulse, an
// hsync line-valid that is high with each emitted pixel, the pixel data,
// and programmable vertical and horizontal blanking.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   tdata_i            AXIS pixel
//   tuser_i            AXIS start of frame
//   tlast_i            AXIS end of line
//   tvalid_i           AXIS valid
//   tready_o           AXIS ready (combinational)
//   vsync_o            DVP frame sync (registered)
//   hsync_o            DVP line valid (registered)
//   data_o             DVP pixel (registered)
//   frame_done_o       one-cycle pulse in the last front-porch cycle
//   err_clr_i          synchronous clear of err_o
//   err_o              sticky framing error
//   dbg_state_o        current FSM state, for observation only
//
// Handshake: a beat transfers on a rising clock edge where tvalid_i and
// tready_o are both high. tready_o never depends on tvalid_i. A beat that
// is not accepted stays on the bus unchanged until it is.
//
// VSYNC_P must be at least 1. VBP_P, HBLANK_P and VFP_P may be 0, in which
// case their state is skipped entirely.
module axis_dvp #(
    parameter int WIDTH_P   = 8,
    parameter int LINE_W_P  = 16,
    parameter int FRAME_H_P = 16,
    parameter int VSYNC_P   = 4,
    parameter int VBP_P     = 4,
    parameter int HBLANK_P  = 4,
    parameter int VFP_P     = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH_P-1:0] tdata_i,
    input  logic               tuser_i,
    input  logic               tlast_i,
    input  logic               tvalid_i,
    output logic               tready_o,
    output logic               vsync_o,
    output logic               hsync_o,
    output logic [WIDTH_P-1:0] data_o,
    output logic               frame_done_o,
    input  logic               err_clr_i,
    output logic               err_o,
    output logic [2:0]         dbg_state_o
);

    // One shared blanking counter, wide enough for the longest blank.
    localparam int M1_L    = (VSYNC_P > VBP_P) ? VSYNC_P : VBP_P;
    localparam int M2_L    = (HBLANK_P > VFP_P) ? HBLANK_P : VFP_P;
    localparam int M3_L    = (M1_L > M2_L) ? M1_L : M2_L;
    localparam int CNT_W   = $clog2((M3_L > 2) ? M3_L : 2);
    localparam int X_W     = $clog2((LINE_W_P > 2) ? LINE_W_P : 2);
    localparam int Y_W     = $clog2((FRAME_H_P > 2) ? FRAME_H_P : 2);

    localparam logic [CNT_W-1:0] VSYNC_LAST  = CNT_W'(VSYNC_P - 1);
    localparam logic [CNT_W-1:0] VBP_LAST    = CNT_W'(VBP_P - 1);
    localparam logic [CNT_W-1:0] HBLANK_LAST = CNT_W'(HBLANK_P - 1);
    localparam logic [CNT_W-1:0] VFP_LAST    = CNT_W'(VFP_P - 1);
    localparam logic [X_W-1:0]   X_LAST      = X_W'(LINE_W_P - 1);
    localparam logic [Y_W-1:0]   Y_LAST      = Y_W'(FRAME_H_P - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBP    = 3'd2,
        S_LINE   = 3'd3,
        S_HBLANK = 3'd4,
        S_VFP    = 3'd5
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic               r_vsync;
    logic               r_hsync;
    logic [WIDTH_P-1:0] r_data;
    logic               r_frame_done;
    logic               r_err;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [X_W-1:0]     w_x_nxt;
    logic [Y_W-1:0]     w_y_nxt;
    logic               w_tready;
    logic               w_accept;
    logic               w_pix_accept;
    logic               w_line_end;
    logic               w_at_origin;
    logic               w_err_det;
    logic               w_hb_exit;
    logic               w_vfp_skip;

    // In IDLE, non-tuser beats are swallowed so a misaligned upstream can
    // resync; the tuser beat itself is held until the first line. Ready is
    // also forced low while reset is asserted.
    always_comb begin
        w_tready = 1'b0;
        case (r_state)
            S_IDLE:  w_tready = ~tuser_i;
            S_LINE:  w_tready = 1'b1;
            default: w_tready = 1'b0;
        endcase
        if (rst_i) begin
            w_tready = 1'b0;
        end
    end

    assign w_accept     = tvalid_i & w_tready;
    assign w_pix_accept = w_accept & (r_state == S_LINE);
    assign w_line_end   = (r_x == X_LAST) | tlast_i;
    assign w_at_origin  = (r_x == '0) & (r_y == '0);

    assign w_err_det = w_pix_accept &
                       ((tlast_i & (r_x != X_LAST)) |
                        ((r_x == X_LAST) & ~tlast_i) |
                        (tuser_i & ~w_at_origin) |
                        (~tuser_i & w_at_origin));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_hb_exit   = 1'b0;
        w_vfp_skip  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tvalid_i && tuser_i) begin
                    w_state_nxt = S_VSYNC;
                    w_cnt_nxt   = '0;
                end
            end
            S_VSYNC: begin
                if (r_cnt == VSYNC_LAST) begin
                    w_cnt_nxt   = '0;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_state_nxt = (VBP_P > 0) ? S_VBP : S_LINE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_VBP: begin
                if (r_cnt == VBP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_state_nxt = S_LINE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_LINE: begin
                if (w_accept) begin
                    if (w_line_end) begin
                        w_x_nxt   = '0;
                        w_cnt_nxt = '0;
                        if (HBLANK_P > 0) begin
                            w_state_nxt = S_HBLANK;
                        end else begin
                            w_hb_exit = 1'b1;
                        end
                    end else begin
                        w_x_nxt = r_x + 1'b1;
                    end
                end
            end
            S_HBLANK: begin
                if (r_cnt == HBLANK_LAST) begin
                    w_cnt_nxt = '0;
                    w_hb_exit = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_VFP: begin
                if (r_cnt == VFP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // End of horizontal blanking, reached from HBLANK or directly from
        // the line when HBLANK_P is 0: next line, or the end of the frame.
        if (w_hb_exit) begin
            if (r_y == Y_LAST) begin
                w_y_nxt = '0;
                if (VFP_P > 0) begin
                    w_state_nxt = S_VFP;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_vfp_skip  = 1'b1;
                end
            end else begin
                w_y_nxt     = r_y + 1'b1;
                w_state_nxt = S_LINE;
            end
        end
    end

    // vsync and frame_done are registered from the next state so they line
    // up with the VSYNC and last-VFP cycles. hsync/data follow the accept by
    // one cycle; on a stall hsync drops and data holds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_vsync      <= 1'b0;
            r_hsync      <= 1'b0;
            r_data       <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_vsync      <= (w_state_nxt == S_VSYNC);
            r_hsync      <= w_pix_accept;
            if (w_pix_accept) begin
                r_data <= tdata_i;
            end
            r_frame_done <= ((w_state_nxt == S_VFP) && (w_cnt_nxt == VFP_LAST)) || w_vfp_skip;
            if (w_err_det) begin
                r_err <= 1'b1;
            end else if (err_clr_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign tready_o     = w_tready;
    assign vsync_o      = r_vsync;
    assign hsync_o      = r_hsync;
    assign data_o       = r_data;
    assign frame_done_o = r_frame_done;
    assign err_o        = r_err;
    assign dbg_state_o  = r_state;

endmodule
